processor_mc: RTL and testbench

//  Multi-cycle 18-bit-ISA core, next generation of the single-cycle processor. Adds loads (op 3) and

---
 rtl/processor_pkg.sv | 59 +++++
 rtl/processor_if.sv | 24 ++
 rtl/alu.sv | 25 ++
 rtl/processor_decode.sv | 43 ++++
 rtl/regfile.sv | 27 ++
 rtl/processor_mc.sv | 115 +++++++++++
 tb/tb_processor_mc.sv | 177 +++++++++++++++++
 7 files changed

// File: rtl/processor_pkg.sv
// Shared types and constants for the multi-cycle core: opcodes, FSM states, ALU op codes,
// decoded-control bundle and the immediate sign-extension helper.
package processor_pkg;

  typedef enum logic [3:0] {
    OP_ADDI = 4'd0,
    OP_LI   = 4'd1,
    OP_LUI  = 4'd2,
    OP_LD   = 4'd3,
    OP_ST   = 4'd4,
    OP_ALU  = 4'd5,
    OP_BNZ  = 4'd6,
    OP_HALT = 4'd15
  } opcode_e;

  typedef enum logic [1:0] {
    StFetch,
    StExec,
    StMem,
    StHalt
  } state_e;

  typedef enum logic [1:0] {
    WB_ADD,
    WB_IMM,
    WB_IMMHI,
    WB_ALU
  } wb_sel_e;

  localparam logic [3:0] ALU_OP_ADD = 4'd0;
  localparam logic [3:0] ALU_OP_SUB = 4'd1;
  localparam logic [3:0] ALU_OP_AND = 4'd2;
  localparam logic [3:0] ALU_OP_OR  = 4'd3;
  localparam logic [3:0] ALU_OP_XOR = 4'd4;
  localparam logic [3:0] ALU_OP_SHL = 4'd5;
  localparam logic [3:0] ALU_OP_SHR = 4'd6;

  typedef struct packed {
    logic [2:0] rx;
    logic [2:0] ry;
    logic [2:0] rz;
    logic [3:0] alu_op;
    wb_sel_e    wb_sel;
    logic       reg_we;
    logic       is_load;
    logic       is_store;
    logic       is_halt;
    logic       is_branch;
  } ctrl_t;

  // Callers keep the low WORD_SIZE bits of the 64-bit result.
  function automatic logic [63:0] sext(input logic [10:0] imm, input int unsigned bits);
    logic [63:0] r;
    if (bits == 8) r = {{56{imm[7]}}, imm[7:0]};
    else           r = {{53{imm[10]}}, imm};
    return r;
  endfunction

endpackage

// File: rtl/processor_if.sv
// Code-ROM and data-RAM bus of the core; master = core side, slave = memory side.
interface processor_if #(
    parameter int unsigned WORD_SIZE = 18,
    parameter int unsigned ADDR_SIZE = 18
) ();
    logic [ADDR_SIZE-1:0] code_addr;
    logic [WORD_SIZE-1:0] code_word;
    logic                 data_write_enable;
    logic                 data_read_enable;
    logic [ADDR_SIZE-1:0] data_addr;
    logic [WORD_SIZE-1:0] data_in;
    logic [WORD_SIZE-1:0] data_out;
    logic                 data_ready;

    modport master (
        output code_addr, data_write_enable, data_read_enable, data_addr, data_in,
        input  code_word, data_out, data_ready
    );

    modport slave (
        input  code_addr, data_write_enable, data_read_enable, data_addr, data_in,
        output code_word, data_out, data_ready
    );
endinterface

// File: rtl/alu.sv
// Combinational ALU; results wrap modulo 2^WIDTH, no flags.
module alu
  import processor_pkg::*;
#(
    parameter int unsigned WIDTH = 18
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [3:0]       op_i,
    output logic [WIDTH-1:0] y_o
);
    always_comb begin
        y_o = '0;
        case (op_i)
            ALU_OP_ADD: y_o = a_i + b_i;
            ALU_OP_SUB: y_o = a_i - b_i;
            ALU_OP_AND: y_o = a_i & b_i;
            ALU_OP_OR:  y_o = a_i | b_i;
            ALU_OP_XOR: y_o = a_i ^ b_i;
            ALU_OP_SHL: y_o = a_i << b_i[4:0];
            ALU_OP_SHR: y_o = a_i >> b_i[4:0];
            default:    y_o = '0;
        endcase
    end
endmodule

// File: rtl/processor_decode.sv
// Combinational instruction decode. Op 6 (branch if rx!=0) decodes only when
// PROCESSOR_BRANCH_EN is defined; otherwise it is a NOP.
module processor_decode
  import processor_pkg::*;
#(
    parameter int unsigned WORD_SIZE = 18
) (
    input  logic [WORD_SIZE-1:0] instr_i,
    output ctrl_t                ctrl_o,
    output logic [WORD_SIZE-1:0] imm8_o,
    output logic [WORD_SIZE-1:0] imm11_o
);
    logic [63:0] imm8_full;
    logic [63:0] imm11_full;
    logic        unused_imm_bits;

    assign imm8_full       = sext(instr_i[10:0], 8);
    assign imm11_full      = sext(instr_i[10:0], 11);
    assign imm8_o          = imm8_full[WORD_SIZE-1:0];
    assign imm11_o         = imm11_full[WORD_SIZE-1:0];
    assign unused_imm_bits = ^{imm8_full[63:WORD_SIZE], imm11_full[63:WORD_SIZE]};

    always_comb begin
        ctrl_o        = '0;
        ctrl_o.rx     = instr_i[13:11];
        ctrl_o.ry     = instr_i[10:8];
        ctrl_o.rz     = instr_i[7:5];
        ctrl_o.alu_op = instr_i[3:0];
        case (instr_i[17:14])
            OP_ADDI: begin ctrl_o.reg_we = 1'b1; ctrl_o.wb_sel = WB_ADD;   end
            OP_LI:   begin ctrl_o.reg_we = 1'b1; ctrl_o.wb_sel = WB_IMM;   end
            OP_LUI:  begin ctrl_o.reg_we = 1'b1; ctrl_o.wb_sel = WB_IMMHI; end
            OP_ALU:  begin ctrl_o.reg_we = 1'b1; ctrl_o.wb_sel = WB_ALU;   end
            OP_LD:   ctrl_o.is_load  = 1'b1;
            OP_ST:   ctrl_o.is_store = 1'b1;
`ifdef PROCESSOR_BRANCH_EN
            OP_BNZ:  ctrl_o.is_branch = 1'b1;
`endif
            OP_HALT: ctrl_o.is_halt  = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: rtl/regfile.sv
// Eight-entry register file: two combinational read ports, one write port, active-high async clear.
module regfile #(
    parameter int unsigned WIDTH = 18
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             we_i,
    input  logic [2:0]       wa_i,
    input  logic [WIDTH-1:0] wd_i,
    input  logic [2:0]       ra1_i,
    input  logic [2:0]       ra2_i,
    output logic [WIDTH-1:0] rd1_o,
    output logic [WIDTH-1:0] rd2_o
);
    logic [WIDTH-1:0] regs_q [8];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < 8; i++) regs_q[i] <= '0;
        end else if (we_i) begin
            regs_q[wa_i] <= wd_i;
        end
    end

    assign rd1_o = regs_q[ra1_i];
    assign rd2_o = regs_q[ra2_i];
endmodule

// File: rtl/processor_mc.sv
// Multi-cycle 18-bit-ISA core: FETCH/EXEC/MEM/HALT FSM around regfile and ALU.
// Optional branch op enabled by PROCESSOR_BRANCH_EN (see processor_decode).
module processor_mc
  import processor_pkg::*;
#(
    parameter int unsigned WORD_SIZE  = 18,
    parameter int unsigned ADDR_SIZE  = 18,
    parameter int unsigned RESET_ADDR = 0
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    processor_if.master  bus_io,
    output logic         halted_o
);
    state_e               state_q, state_d;
    logic [ADDR_SIZE-1:0] ip_q, ip_d;
    logic [WORD_SIZE-1:0] instr_q, instr_d;

    logic [WORD_SIZE-1:0] instr;
    ctrl_t                ctrl;
    logic [WORD_SIZE-1:0] imm8, imm11;
    logic [2:0]           ra2;
    logic [WORD_SIZE-1:0] rd1, rd2, alu_y, mem_addr;
    logic                 rf_we;
    logic [WORD_SIZE-1:0] rf_wd;

    // ROM output is only valid in EXEC; MEM works from the latched copy.
    assign instr = (state_q == StExec) ? bus_io.code_word : instr_q;

    processor_decode #(.WORD_SIZE(WORD_SIZE)) u_decode (
        .instr_i (instr),
        .ctrl_o  (ctrl),
        .imm8_o  (imm8),
        .imm11_o (imm11)
    );

    assign ra2 = (ctrl.wb_sel == WB_ALU && ctrl.reg_we) ? ctrl.rz : ctrl.rx;

    regfile #(.WIDTH(WORD_SIZE)) u_rf (
        .clk_i (clk_i),
        .rst_i (~rst_ni),
        .we_i  (rf_we),
        .wa_i  (ctrl.rx),
        .wd_i  (rf_wd),
        .ra1_i (ctrl.ry),
        .ra2_i (ra2),
        .rd1_o (rd1),
        .rd2_o (rd2)
    );

    alu #(.WIDTH(WORD_SIZE)) u_alu (
        .a_i  (rd1),
        .b_i  (rd2),
        .op_i (ctrl.alu_op),
        .y_o  (alu_y)
    );

    assign mem_addr = rd1 + imm8;

    always_comb begin
        state_d = state_q;
        ip_d    = ip_q;
        instr_d = instr_q;
        rf_we   = 1'b0;
        rf_wd   = alu_y;
        case (state_q)
            StFetch: state_d = StExec;
            StExec: begin
                instr_d = bus_io.code_word;
                ip_d    = ip_q + ADDR_SIZE'(1);
                rf_we   = ctrl.reg_we;
                case (ctrl.wb_sel)
                    WB_ADD:   rf_wd = rd1 + imm8;
                    WB_IMM:   rf_wd = imm11;
                    WB_IMMHI: rf_wd = imm11 << 7;
                    default:  rf_wd = alu_y;
                endcase
                if (ctrl.is_branch && rd2 != '0) begin
                    ip_d = ip_q + ADDR_SIZE'(1) + imm11[ADDR_SIZE-1:0];
                end
                if (ctrl.is_load || ctrl.is_store) state_d = StMem;
                else if (ctrl.is_halt)             state_d = StHalt;
                else                               state_d = StFetch;
            end
            StMem: begin
                if (bus_io.data_ready) begin
                    state_d = StFetch;
                    rf_we   = ctrl.is_load;
                    rf_wd   = bus_io.data_out;
                end
            end
            StHalt:  state_d = StHalt;
            default: state_d = StFetch;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StFetch;
            ip_q    <= ADDR_SIZE'(RESET_ADDR);
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            ip_q    <= ip_d;
            instr_q <= instr_d;
        end
    end

    assign bus_io.code_addr         = ip_q;
    assign bus_io.data_write_enable = (state_q == StMem) && ctrl.is_store;
    assign bus_io.data_read_enable  = (state_q == StMem) && ctrl.is_load;
    assign bus_io.data_addr         = mem_addr[ADDR_SIZE-1:0];
    assign bus_io.data_in           = rd2;
    assign halted_o                 = (state_q == StHalt);
endmodule

// File: tb/tb_processor_mc.sv
// Directed bench for processor_mc: synchronous code ROM model, hand-driven data memory handshake.
module tb_processor_mc;
    import processor_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        halted;
    logic [17:0] rom [32];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_branch;

    processor_if #(.WORD_SIZE(18), .ADDR_SIZE(18)) bus ();

    processor_mc #(.WORD_SIZE(18), .ADDR_SIZE(18), .RESET_ADDR(0)) u_dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .bus_io   (bus),
        .halted_o (halted)
    );

    always #5 clk = ~clk;

    always @(posedge clk) bus.code_word <= rom[bus.code_addr[4:0]];

    function automatic logic [17:0] enc_i8(input logic [3:0] op, input logic [2:0] rx,
                                           input logic [2:0] ry, input logic [7:0] imm);
        return {op, rx, ry, imm};
    endfunction

    function automatic logic [17:0] enc_i11(input logic [3:0] op, input logic [2:0] rx,
                                            input logic [10:0] imm);
        return {op, rx, imm};
    endfunction

    function automatic logic [17:0] enc_r(input logic [2:0] rx, input logic [2:0] ry,
                                          input logic [2:0] rz, input logic [3:0] aop);
        return {4'd5, rx, ry, rz, 1'b0, aop};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rom[i] = {4'd7, 14'd0};
        rom[0] = enc_i11(4'd1, 3'd1, 11'd5);           // r1 = 5
        rom[1] = enc_i8(4'd0, 3'd2, 3'd1, 8'hFD);      // r2 = r1 - 3
        rom[2] = enc_i11(4'd2, 3'd4, 11'h7FF);         // r4 = sext(0x7FF) << 7
        rom[3] = enc_i11(4'd1, 3'd5, 11'h400);         // r5 = sext(0x400)
        rom[4] = enc_i8(4'd4, 3'd2, 3'd1, 8'h04);      // mem[r1+4] = r2
        rom[5] = enc_i8(4'd3, 3'd3, 3'd1, 8'h04);      // r3 = mem[r1+4]
        rom[6] = enc_r(3'd6, 3'd3, 3'd1, ALU_OP_SUB);  // r6 = r3 - r1
        rom[7] = {4'hF, 14'd0};                        // HALT

        rst_n          = 1'b1;
        bus.data_out   = '0;
        bus.data_ready = 1'b0;
        #3 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        release_reset();

        check("reset_code_addr", 32'(bus.code_addr), 32'd0);
        check("reset_halted", 32'(halted), 32'd0);
        check("reset_enables", 32'({bus.data_write_enable, bus.data_read_enable}), 32'd0);
        check("reset_r1", 32'(u_dut.u_rf.regs_q[1]), 32'd0);

        step(); check("e1_code_addr", 32'(bus.code_addr), 32'd0);
        step(); check("e2_code_addr", 32'(bus.code_addr), 32'd1);
        check("li_r1", 32'(u_dut.u_rf.regs_q[1]), 32'd5);
        step(); check("e3_code_addr", 32'(bus.code_addr), 32'd1);
        check("addi_r2_not_yet", 32'(u_dut.u_rf.regs_q[2]), 32'd0);
        step(); check("e4_code_addr", 32'(bus.code_addr), 32'd2);
        check("addi_r2", 32'(u_dut.u_rf.regs_q[2]), 32'd2);

        repeat (4) step();
        check("lui_r4", 32'(u_dut.u_rf.regs_q[4]), 32'h3FF80);
        check("li_neg_r5", 32'(u_dut.u_rf.regs_q[5]), 32'h3FC00);
        check("e8_code_addr", 32'(bus.code_addr), 32'd4);

        step(); check("st_exec_we", 32'(bus.data_write_enable), 32'd0);
        for (int k = 0; k < 4; k++) begin
            step();
            check("st_we_held", 32'(bus.data_write_enable), 32'd1);
            check("st_re_low", 32'(bus.data_read_enable), 32'd0);
            check("st_addr", 32'(bus.data_addr), 32'd9);
            check("st_data", 32'(bus.data_in), 32'd2);
            check("st_ip_stall", 32'(bus.code_addr), 32'd5);
            if (k == 3) bus.data_ready = 1'b1;
        end
        step(); bus.data_ready = 1'b0;
        check("st_we_drop", 32'(bus.data_write_enable), 32'd0);
        check("st_next_fetch", 32'(bus.code_addr), 32'd5);

        step(); check("ld_exec_re", 32'(bus.data_read_enable), 32'd0);
        step();
        check("ld_re", 32'(bus.data_read_enable), 32'd1);
        check("ld_we_low", 32'(bus.data_write_enable), 32'd0);
        check("ld_addr", 32'(bus.data_addr), 32'd9);
        bus.data_out   = 18'd2;
        bus.data_ready = 1'b1;
        step(); bus.data_ready = 1'b0;
        check("ld_r3", 32'(u_dut.u_rf.regs_q[3]), 32'd2);
        check("ld_re_drop", 32'(bus.data_read_enable), 32'd0);
        check("ld_next_fetch", 32'(bus.code_addr), 32'd6);

        repeat (2) step();
        check("alu_sub_r6", 32'(u_dut.u_rf.regs_q[6]), 32'h3FFFD);
        check("e19_code_addr", 32'(bus.code_addr), 32'd7);
        step(); check("halt_exec", 32'(halted), 32'd0);
        step();
        check("halted", 32'(halted), 32'd1);
        check("halt_code_addr", 32'(bus.code_addr), 32'd8);

        bus.data_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step();
            check("halt_frozen", 32'(bus.code_addr), 32'd8);
            check("halt_stays", 32'(halted), 32'd1);
            check("halt_no_req", 32'({bus.data_write_enable, bus.data_read_enable}), 32'd0);
        end
        bus.data_ready = 1'b0;

        #2 rst_n = 1'b0;
        #1;
        check("rst_code_addr", 32'(bus.code_addr), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_r3", 32'(u_dut.u_rf.regs_q[3]), 32'd0);
        release_reset();

        // Abort a stalled store with an asynchronous reset.
        repeat (10) step();
        check("abort_we_before", 32'(bus.data_write_enable), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_we", 32'(bus.data_write_enable), 32'd0);
        check("abort_code_addr", 32'(bus.code_addr), 32'd0);

        for (int i = 1; i < 32; i++) rom[i] = {4'd7, 14'd0};
        rom[0]  = enc_i11(4'd1, 3'd1, 11'd1);
        rom[10] = enc_i11(4'd6, 3'd1, 11'h7FE);
`ifdef PROCESSOR_BRANCH_EN
        exp_branch = 32'd9;
`else
        exp_branch = 32'd11;
`endif
        release_reset();
        repeat (21) step();
        check("br_exec_addr", 32'(bus.code_addr), 32'd10);
        step(); check("br_taken", 32'(bus.code_addr), exp_branch);

        #2 rst_n = 1'b0;
        rom[0] = enc_i11(4'd1, 3'd1, 11'd0);
        release_reset();
        repeat (22) step();
        check("br_not_taken", 32'(bus.code_addr), 32'd11);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
